// File: rtl/rx_char_sequencer.sv
// rx_char_sequencer
// Sits between the ISO7816 receive core and the host byte interface.
// - Captures good characters into a 2-entry FIFO with a valid/ready handshake.
// - Reports frame/parity errors and acknowledges the receive core's flags.
// - Runs the waiting-time (WWT) supervisor.
// Optional feature: define RX_SEQ_ERROR_SIGNAL_EN to compile in the T=0
// error-signal states (ERR_WAIT, ERR_DRIVE, ERR_END).
// Without RX_SEQ_ERROR_SIGNAL_EN:
// - every frame error is only reported;
// - ioDriveLow is tied low.

module rx_char_sequencer #(
    parameter int CLOCK_PER_BIT_WIDTH = 13,
    parameter int WT_WIDTH            = 16
) (
    input  logic                           clk,
    input  logic                           nReset,
    input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
    input  logic [7:0]                     rxDataIn,
    input  logic                           rxReadyFlag,
    input  logic                           rxFrameErrorFlag,
    input  logic                           rxOverrunFlag,
    input  logic                           rxRun,
    input  logic                           rxEndOfRx,
    output logic                           ackFlags,
    input  logic                           errSigEnable,
    input  logic [2:0]                     maxRetries,
    input  logic [WT_WIDTH-1:0]            waitTime,
    output logic                           ioDriveLow,
    output logic [7:0]                     dataOut,
    output logic                           dataValid,
    input  logic                           dataReady,
    output logic [2:0]                     parityErrorCount,
    output logic                           retryExhausted,
    output logic                           overrun,
    output logic                           timeout,
    input  logic                           clearStatus
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE
`ifdef RX_SEQ_ERROR_SIGNAL_EN
        ,
        ERR_WAIT,
        ERR_DRIVE,
        ERR_END
`endif
    } SeqState;

    SeqState state;

    logic readySync;
    logic readyQ;
    logic frameSync;
    logic frameQ;
    logic readyRise;
    logic frameRise;

    logic [7:0] fifoMem [2];
    logic       wrPtr;
    logic       rdPtr;
    logic [1:0] fifoCount;
    logic       fifoFull;
    logic       push;
    logic       pop;
    logic       drop;

    logic [2:0] incCount;
    logic [CLOCK_PER_BIT_WIDTH-1:0] cpbMinus1;

    logic [CLOCK_PER_BIT_WIDTH-1:0] wwtPresc;
    logic [WT_WIDTH-1:0]            wwtEtu;
    logic                           wwtRunning;

`ifdef RX_SEQ_ERROR_SIGNAL_EN
    logic [CLOCK_PER_BIT_WIDTH-1:0] errCnt;
    logic                           driveLowReg;
    logic                           takeErrPath;

    assign takeErrPath = errSigEnable && (parityErrorCount < maxRetries);
    assign ioDriveLow  = driveLowReg;
`else
    logic unusedErrSigEnable;

    assign unusedErrSigEnable = errSigEnable;
    assign ioDriveLow         = 1'b0;
`endif

    assign readyRise = readySync & ~readyQ;
    assign frameRise = frameSync & ~frameQ;

    assign fifoFull  = (fifoCount == 2'd2);
    assign dataValid = (fifoCount != 2'd0);
    assign dataOut   = fifoMem[rdPtr];
    assign pop       = dataValid & dataReady;
    // A full FIFO that is popping in the same cycle still has room for the new byte.
    assign push      = (state == CAPTURE) && (!fifoFull || pop);
    assign drop      = (state == CAPTURE) && fifoFull && !pop;

    assign incCount  = (parityErrorCount == 3'd7) ? 3'd7 : parityErrorCount + 3'd1;
    assign cpbMinus1 = clocksPerBit - 1'b1;

    // Sample the receive-core flags and keep the previous sample so only rising edges act.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            readySync <= 1'b0;
            readyQ    <= 1'b0;
            frameSync <= 1'b0;
            frameQ    <= 1'b0;
        end else begin
            readySync <= rxReadyFlag;
            readyQ    <= readySync;
            frameSync <= rxFrameErrorFlag;
            frameQ    <= frameSync;
        end
    end

    // Sequencer:
    // - acks the receive core;
    // - tracks consecutive errors;
    // - owns the sticky error/overrun flags;
    // - drives the T=0 error signal.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state            <= IDLE;
            ackFlags         <= 1'b0;
            parityErrorCount <= 3'd0;
            retryExhausted   <= 1'b0;
            overrun          <= 1'b0;
`ifdef RX_SEQ_ERROR_SIGNAL_EN
            errCnt           <= '0;
            driveLowReg      <= 1'b0;
`endif
        end else begin
            ackFlags <= 1'b0;

            case (state)
                IDLE: begin
`ifdef RX_SEQ_ERROR_SIGNAL_EN
                    if (frameRise && takeErrPath) begin
                        state  <= ERR_WAIT;
                        errCnt <= '0;
                    end else
`endif
                    if (frameRise) begin
                        ackFlags         <= 1'b1;
                        parityErrorCount <= incCount;
                        if (incCount >= maxRetries) begin
                            retryExhausted <= 1'b1;
                        end
                    end else if (readyRise) begin
                        state    <= CAPTURE;
                        ackFlags <= 1'b1;
                    end
                end

                CAPTURE: begin
                    parityErrorCount <= 3'd0;
                    state            <= IDLE;
                end

`ifdef RX_SEQ_ERROR_SIGNAL_EN
                ERR_WAIT: begin
                    if (errCnt == cpbMinus1) begin
                        state       <= ERR_DRIVE;
                        errCnt      <= '0;
                        driveLowReg <= 1'b1;
                    end else begin
                        errCnt <= errCnt + 1'b1;
                    end
                end

                ERR_DRIVE: begin
                    if (errCnt == cpbMinus1) begin
                        state       <= ERR_END;
                        errCnt      <= '0;
                        driveLowReg <= 1'b0;
                    end else begin
                        errCnt <= errCnt + 1'b1;
                    end
                end

                ERR_END: begin
                    if (!rxRun) begin
                        state            <= IDLE;
                        ackFlags         <= 1'b1;
                        parityErrorCount <= incCount;
                        if (incCount >= maxRetries) begin
                            retryExhausted <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase

            if (clearStatus) begin
                parityErrorCount <= 3'd0;
                retryExhausted   <= 1'b0;
            end

            // A byte dropped on a full FIFO beats a simultaneous clear.
            // A clear beats the receive core's overrun level.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clearStatus) begin
                overrun <= 1'b0;
            end else if (rxOverrunFlag) begin
                overrun <= 1'b1;
            end
        end
    end

    // Two-entry host FIFO with wrapping one-bit pointers.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            fifoMem[0] <= 8'h00;
            fifoMem[1] <= 8'h00;
            wrPtr      <= 1'b0;
            rdPtr      <= 1'b0;
            fifoCount  <= 2'd0;
        end else begin
            if (push) begin
                fifoMem[wrPtr] <= rxDataIn;
                wrPtr          <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            if (push && !pop) begin
                fifoCount <= fifoCount + 2'd1;
            end else if (pop && !push) begin
                fifoCount <= fifoCount - 2'd1;
            end
        end
    end

    assign wwtRunning = (state == IDLE) && !rxRun && (wwtEtu != waitTime);

    // Waiting-time supervisor.
    // - Counts whole etus while the line is idle.
    // - Restarts on end-of-character or clear.
    // - Holds once the limit is reached.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wwtPresc <= '0;
            wwtEtu   <= '0;
            timeout  <= 1'b0;
        end else if (clearStatus || rxEndOfRx || (waitTime == '0)) begin
            wwtPresc <= '0;
            wwtEtu   <= '0;
            if (clearStatus) begin
                timeout <= 1'b0;
            end
        end else if (wwtRunning) begin
            if (wwtPresc == cpbMinus1) begin
                wwtPresc <= '0;
                wwtEtu   <= wwtEtu + 1'b1;
                if ((wwtEtu + 1'b1) == waitTime) begin
                    timeout <= 1'b1;
                end
            end else begin
                wwtPresc <= wwtPresc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_char_sequencer.sv
// tb_rx_char_sequencer
// Directed bench for rx_char_sequencer.
// - Stimulus pushes expected bytes into a scoreboard queue.
// - A monitor pops and compares whenever the DUT hands a byte to the host.
// - Error-signal checks follow RX_SEQ_ERROR_SIGNAL_EN when it is defined.

module tb_rx_char_sequencer;

    logic        clk;
    logic        nReset;
    logic [12:0] clocksPerBit;
    logic [7:0]  rxDataIn;
    logic        rxReadyFlag;
    logic        rxFrameErrorFlag;
    logic        rxOverrunFlag;
    logic        rxRun;
    logic        rxEndOfRx;
    logic        ackFlags;
    logic        errSigEnable;
    logic [2:0]  maxRetries;
    logic [15:0] waitTime;
    logic        ioDriveLow;
    logic [7:0]  dataOut;
    logic        dataValid;
    logic        dataReady;
    logic [2:0]  parityErrorCount;
    logic        retryExhausted;
    logic        overrun;
    logic        timeout;
    logic        clearStatus;

    int checksTotal = 0;
    int checksPassed = 0;
    int ackCount = 0;
    int driveCycles = 0;
    int validCycles = 0;
    int startAck;
    int waited;
    int cycles;
    int expectedDrive;
    logic ackPrev = 1'b0;
    logic [7:0] expByte;
    logic [7:0] sbQueue [$];

    rx_char_sequencer #(
        .CLOCK_PER_BIT_WIDTH(13),
        .WT_WIDTH(16)
    ) dut (
        .clk(clk),
        .nReset(nReset),
        .clocksPerBit(clocksPerBit),
        .rxDataIn(rxDataIn),
        .rxReadyFlag(rxReadyFlag),
        .rxFrameErrorFlag(rxFrameErrorFlag),
        .rxOverrunFlag(rxOverrunFlag),
        .rxRun(rxRun),
        .rxEndOfRx(rxEndOfRx),
        .ackFlags(ackFlags),
        .errSigEnable(errSigEnable),
        .maxRetries(maxRetries),
        .waitTime(waitTime),
        .ioDriveLow(ioDriveLow),
        .dataOut(dataOut),
        .dataValid(dataValid),
        .dataReady(dataReady),
        .parityErrorCount(parityErrorCount),
        .retryExhausted(retryExhausted),
        .overrun(overrun),
        .timeout(timeout),
        .clearStatus(clearStatus)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checksTotal++;
        if (actual >= lo && actual <= hi) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Raise a receive-core flag, wait (bounded) for the ack, then drop the flag.
    task automatic applyStimulus(input logic isError, input logic [7:0] data, input logic expectStore);
        int ackBase;
        int loops;
        ackBase = ackCount;
        rxDataIn = data;
        if (expectStore) sbQueue.push_back(data);
        if (isError) rxFrameErrorFlag = 1'b1;
        else rxReadyFlag = 1'b1;
        loops = 0;
        while (ackCount == ackBase && loops < 3000) begin
            @(posedge clk); #1;
            loops++;
        end
        rxReadyFlag = 1'b0;
        rxFrameErrorFlag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput(isError ? "errAckCount" : "byteAckCount", ackCount - ackBase, 1);
    endtask

    task automatic waitTimeout(output int n);
        n = 0;
        while (!timeout && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pulseClear();
        clearStatus = 1'b1;
        @(posedge clk); #1;
        clearStatus = 1'b0;
    endtask

    // Monitor:
    // - scoreboard compare on every host transfer;
    // - ack pulse width;
    // - activity counters.
    always @(negedge clk) begin
        if (nReset) begin
            if (ackFlags) begin
                ackCount++;
                checkOutput("ackWidth", ackPrev, 0);
            end
            if (ioDriveLow) driveCycles++;
            if (dataValid) validCycles++;
            if (dataValid && dataReady) begin
                if (sbQueue.size() == 0) begin
                    checksTotal++;
                    $display("[TB] FAIL sbUnexpected: got dataOut %0h, required no transfer", dataOut);
                end else begin
                    expByte = sbQueue.pop_front();
                    checkOutput("sbData", dataOut, expByte);
                end
            end
        end
        ackPrev = ackFlags;
    end

    // Directed test sequence.
    initial begin
        nReset = 1'b0;
        clocksPerBit = 13'd8;
        rxDataIn = 8'h00;
        rxReadyFlag = 1'b0;
        rxFrameErrorFlag = 1'b0;
        rxOverrunFlag = 1'b0;
        rxRun = 1'b0;
        rxEndOfRx = 1'b0;
        errSigEnable = 1'b1;
        maxRetries = 3'd4;
        waitTime = 16'd0;
        dataReady = 1'b1;
        clearStatus = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstAck", ackFlags, 0);
        checkOutput("rstDrive", ioDriveLow, 0);
        checkOutput("rstDataOut", dataOut, 8'h00);
        checkOutput("rstValid", dataValid, 0);
        checkOutput("rstCount", parityErrorCount, 0);
        checkOutput("rstExhausted", retryExhausted, 0);
        checkOutput("rstOverrun", overrun, 0);
        checkOutput("rstTimeout", timeout, 0);
        nReset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Good byte with latency checks.
        validCycles = 0;
        startAck = ackCount;
        rxDataIn = 8'h3B;
        sbQueue.push_back(8'h3B);
        rxReadyFlag = 1'b1;
        @(posedge clk); #1;
        checkOutput("latAckEdgeN", ackFlags, 0);
        @(posedge clk); #1;
        checkOutput("latAckEdgeN1", ackFlags, 1);
        checkOutput("latValidEdgeN1", dataValid, 0);
        @(posedge clk); #1;
        checkOutput("latAckEdgeN2", ackFlags, 0);
        checkOutput("latValidEdgeN2", dataValid, 1);
        rxReadyFlag = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("goodAckCount", ackCount - startAck, 1);
        checkOutput("goodValidCycles", validCycles, 1);
        checkOutput("goodCount", parityErrorCount, 0);

        // Overflow: third byte dropped, first two popped in order.
        dataReady = 1'b0;
        applyStimulus(1'b0, 8'hA1, 1'b1);
        applyStimulus(1'b0, 8'hA2, 1'b1);
        checkOutput("ovfBeforeThird", overrun, 0);
        applyStimulus(1'b0, 8'hA3, 1'b0);
        checkOutput("ovfAfterThird", overrun, 1);
        checkOutput("ovfFullValid", dataValid, 1);
        dataReady = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("ovfDrained", sbQueue.size(), 0);
        checkOutput("ovfEmpty", dataValid, 0);
        pulseClear();
        checkOutput("ovfCleared", overrun, 0);

        // Frame errors and retry exhaustion.
        driveCycles = 0;
        errSigEnable = 1'b1;
        maxRetries = 3'd4;
`ifdef RX_SEQ_ERROR_SIGNAL_EN
        clocksPerBit = 13'd372;
        rxRun = 1'b1;
        startAck = ackCount;
        rxFrameErrorFlag = 1'b1;
        @(posedge clk); #1;
        repeat (372) @(posedge clk);
        #1;
        checkOutput("drive372", ioDriveLow, 0);
        rxFrameErrorFlag = 1'b0;
        @(posedge clk); #1;
        checkOutput("drive373", ioDriveLow, 1);
        repeat (371) @(posedge clk);
        #1;
        checkOutput("drive744", ioDriveLow, 1);
        @(posedge clk); #1;
        checkOutput("drive745", ioDriveLow, 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ackHeldByRun", ackCount - startAck, 0);
        rxRun = 1'b0;
        waited = 0;
        while (ackCount == startAck && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("ackAfterRun", ackCount - startAck, 1);
        expectedDrive = 372 + 3 * 8;
`else
        applyStimulus(1'b1, 8'h00, 1'b0);
        expectedDrive = 0;
`endif
        checkOutput("errCount1", parityErrorCount, 1);
        clocksPerBit = 13'd8;
        for (int i = 2; i <= 4; i++) begin
            applyStimulus(1'b1, 8'h00, 1'b0);
            checkOutput("errCount", parityErrorCount, i);
            checkOutput("errExhausted", retryExhausted, (i >= 4) ? 1 : 0);
        end
        checkOutput("driveTotal", driveCycles, expectedDrive);
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("fifthNoDrive", driveCycles, expectedDrive);
        checkOutput("fifthCount", parityErrorCount, 5);
        checkOutput("fifthExhausted", retryExhausted, 1);
        applyStimulus(1'b0, 8'hC4, 1'b1);
        checkOutput("goodResetsCount", parityErrorCount, 0);
        checkOutput("exhaustedSticky", retryExhausted, 1);
        pulseClear();
        checkOutput("exhaustedCleared", retryExhausted, 0);

        // Waiting-time supervisor.
        clocksPerBit = 13'd16;
        waitTime = 16'd10;
        rxEndOfRx = 1'b1;
        @(posedge clk); #1;
        rxEndOfRx = 1'b0;
        waitTimeout(cycles);
        checkRange("wwtExpiry", cycles, 159, 161);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("timeoutHeld", timeout, 1);
        pulseClear();
        checkOutput("timeoutCleared", timeout, 0);
        waitTimeout(cycles);
        checkRange("wwtRestart", cycles, 159, 161);

        // Async reset with buffered data, sticky flags and (if built) an active error signal.
        clocksPerBit = 13'd8;
        dataReady = 1'b0;
        applyStimulus(1'b0, 8'h5C, 1'b1);
        rxOverrunFlag = 1'b1;
        @(posedge clk); #1;
        rxOverrunFlag = 1'b0;
        checkOutput("ovfFlagSets", overrun, 1);
        checkOutput("preResetValid", dataValid, 1);
`ifdef RX_SEQ_ERROR_SIGNAL_EN
        clocksPerBit = 13'd372;
        rxFrameErrorFlag = 1'b1;
        waited = 0;
        while (!ioDriveLow && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("driveBeforeReset", ioDriveLow, 1);
`endif
        #2;
        nReset = 1'b0;
        #1;
        checkOutput("arstDrive", ioDriveLow, 0);
        checkOutput("arstValid", dataValid, 0);
        checkOutput("arstDataOut", dataOut, 8'h00);
        checkOutput("arstOverrun", overrun, 0);
        checkOutput("arstTimeout", timeout, 0);
        checkOutput("arstAck", ackFlags, 0);
        sbQueue.delete();
        rxFrameErrorFlag = 1'b0;
        clocksPerBit = 13'd8;
        @(posedge clk); #1;
        nReset = 1'b1;
        dataReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h77, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("finalDrained", sbQueue.size(), 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
